// File: rtl/sa_tag_lookup_lru.sv
// Set-associative tag store with a per-way serial lookup and true-LRU allocate-on-miss.
// Optional write-back dirty tracking is enabled by defining DIRTY_WB_EN.
module sa_tag_lookup_lru #(
  parameter int WAYS        = 4,
  parameter int BLOCK_BYTES = 16,
  parameter int CACHE_BYTES = 32768,
  parameter int ADDR_W      = 32
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        req_valid,
  output logic                                        req_ready,
  input  logic [ADDR_W-1:0]                           req_addr,
  input  logic                                        req_write,
  output logic                                        resp_valid,
  output logic                                        resp_hit,
  output logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0]  resp_way,
  output logic                                        evict_valid,
  output logic [ADDR_W-1:0]                           evict_addr,
  output logic [31:0]                                 hit_count,
  output logic [31:0]                                 miss_count,
  output logic [31:0]                                 wb_count
);

  localparam int SETS  = CACHE_BYTES / (BLOCK_BYTES * WAYS);
  localparam int OFF_W = $clog2(BLOCK_BYTES);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(WAYS - 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESP} state_t;

  state_t             state, state_next;
  logic [TAG_W-1:0]   tag_q;
  logic [IDX_W-1:0]   idx_q;
  logic               write_q;
  logic [WAY_W-1:0]   way_ptr;

  logic               valid_mem [SETS][WAYS];
  logic [WAY_W-1:0]   age_mem   [SETS][WAYS];
  logic [TAG_W-1:0]   tag_mem   [SETS][WAYS];

  logic               lookup_hit;
  logic [WAY_W-1:0]   victim;
  logic               victim_found;
  logic               promote_en;
  logic [WAY_W-1:0]   promote_way;
  logic [WAY_W-1:0]   promote_age;
  logic               unused_bits;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  assign lookup_hit = valid_mem[idx_q][way_ptr] && (tag_mem[idx_q][way_ptr] == tag_q);

  // Lowest invalid way wins; otherwise the way holding the oldest age.
  always_comb begin
    victim       = '0;
    victim_found = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (!victim_found && !valid_mem[idx_q][i]) begin
        victim       = WAY_W'(i);
        victim_found = 1'b1;
      end
    end
    if (!victim_found) begin
      for (int i = 0; i < WAYS; i++) begin
        if (age_mem[idx_q][i] == LAST_WAY) victim = WAY_W'(i);
      end
    end
  end

  assign promote_en  = ((state == LOOKUP) && lookup_hit) || (state == FILL);
  assign promote_way = (state == FILL) ? victim : way_ptr;
  assign promote_age = age_mem[idx_q][promote_way];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (req_valid) state_next = LOOKUP;
      LOOKUP:  if (lookup_hit)                state_next = RESP;
               else if (way_ptr == LAST_WAY)  state_next = FILL;
      FILL:    state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q    <= '0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      way_ptr  <= '0;
      resp_hit <= 1'b0;
      resp_way <= '0;
    end else begin
      unique case (state)
        IDLE: if (req_valid) begin
          tag_q   <= req_addr[ADDR_W-1 -: TAG_W];
          idx_q   <= req_addr[OFF_W +: IDX_W];
          write_q <= req_write;
          way_ptr <= '0;
        end
        LOOKUP: begin
          if (lookup_hit) begin
            resp_hit <= 1'b1;
            resp_way <= way_ptr;
          end else if (way_ptr != LAST_WAY) begin
            way_ptr <= way_ptr + 1'b1;
          end
        end
        FILL: begin
          resp_hit <= 1'b0;
          resp_way <= victim;
        end
        default: ;
      endcase
    end
  end

  // NOTE: valid and age arrays are reset because lookup and LRU depend on them; tags are not, valid qualifies them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_mem[s][w] <= 1'b0;
          age_mem[s][w]   <= WAY_W'(w);
        end
      end
    end else begin
      if (state == FILL) valid_mem[idx_q][victim] <= 1'b1;
      if (promote_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == promote_way)           age_mem[idx_q][w] <= '0;
          else if (age_mem[idx_q][w] < promote_age) age_mem[idx_q][w] <= age_mem[idx_q][w] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == FILL) tag_mem[idx_q][victim] <= tag_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == RESP) begin
      if (resp_hit) begin
        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end
    end
  end

`ifdef DIRTY_WB_EN
  logic dirty_mem [SETS][WAYS];
  logic evict_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) dirty_mem[s][w] <= 1'b0;
      end
    end else if ((state == LOOKUP) && lookup_hit && write_q) begin
      dirty_mem[idx_q][way_ptr] <= 1'b1;
    end else if (state == FILL) begin
      dirty_mem[idx_q][victim] <= write_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evict_pend <= 1'b0;
      evict_addr <= '0;
      wb_count   <= '0;
    end else begin
      if (state == FILL) begin
        evict_pend <= valid_mem[idx_q][victim] && dirty_mem[idx_q][victim];
        if (valid_mem[idx_q][victim] && dirty_mem[idx_q][victim])
          evict_addr <= {tag_mem[idx_q][victim], idx_q, {OFF_W{1'b0}}};
      end else if (state == RESP) begin
        evict_pend <= 1'b0;
        if (evict_pend && (wb_count != 32'hFFFF_FFFF)) wb_count <= wb_count + 32'd1;
      end
    end
  end

  assign evict_valid = evict_pend && (state == RESP);
  assign unused_bits = ^req_addr[OFF_W-1:0];
`else
  assign evict_valid = 1'b0;
  assign evict_addr  = '0;
  assign wb_count    = '0;
  assign unused_bits = ^{req_write, write_q, req_addr[OFF_W-1:0]};
`endif

endmodule
